// File: rtl/i2c_frame_capture.sv
// rtl/i2c_frame_capture.sv - passive I2C capture of address and first data byte into one 16-bit frame
module i2c_frame_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic [15:0] o_data,
  output logic [1:0]  o_ack,
  output logic        o_valid,
  output logic        o_nack,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    BYTE0,
    ACK0,
    BYTE1,
    ACK1,
    WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   w_rise;
  logic                   w_start;
  logic                   w_stop;

  logic                   r_rise;
  logic                   r_start;
  logic                   r_stop;
  logic                   r_sda_q;

  state_t                 r_state;
  logic [2:0]             r_bcnt;
  logic [15:0]            r_shift;
  logic                   r_ack0;
  logic [15:0]            r_data;
  logic [1:0]             r_ack;
  logic                   r_valid;
  logic                   r_nack;
  logic                   r_err;
  logic                   r_busy;
  logic                   w_in_frame;

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // Bus conditions only count when SCL is stable high across both samples.
  assign w_rise  = w_scl_s & ~r_scl_d;
  assign w_start = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop  = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  // Event register stage gives the fixed SYNC_STAGES+2 raw-edge-to-output latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise  <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_sda_q <= 1'b1;
    end else begin
      r_rise  <= w_rise;
      r_start <= w_start;
      r_stop  <= w_stop;
      r_sda_q <= w_sda_s;
    end
  end

  assign w_in_frame = (r_state == BYTE0) || (r_state == ACK0) ||
                      (r_state == BYTE1) || (r_state == ACK1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_bcnt  <= 3'd0;
      r_shift <= 16'd0;
      r_ack0  <= 1'b0;
      r_data  <= 16'd0;
      r_ack   <= 2'd0;
      r_valid <= 1'b0;
      r_nack  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_nack  <= 1'b0;
      r_err   <= 1'b0;
      if (r_stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_err   <= w_in_frame;
      end else if (r_start) begin
        r_state <= BYTE0;
        r_bcnt  <= 3'd0;
        r_shift <= 16'd0;
        r_busy  <= 1'b1;
        r_err   <= w_in_frame;
      end else if (r_rise) begin
        case (r_state)
          BYTE0, BYTE1: begin
            r_shift <= {r_shift[14:0], r_sda_q};
            if (r_bcnt == 3'd7) begin
              r_state <= (r_state == BYTE0) ? ACK0 : ACK1;
            end else begin
              r_bcnt <= r_bcnt + 3'd1;
            end
          end
          ACK0: begin
            r_ack0 <= r_sda_q;
            if (r_sda_q) begin
              r_nack  <= 1'b1;
              r_state <= WAIT_STOP;
            end else begin
              r_state <= BYTE1;
              r_bcnt  <= 3'd0;
            end
          end
          ACK1: begin
            r_data  <= r_shift;
            r_ack   <= {r_ack0, r_sda_q};
            r_valid <= 1'b1;
            r_state <= WAIT_STOP;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_data  = r_data;
  assign o_ack   = r_ack;
  assign o_valid = r_valid;
  assign o_nack  = r_nack;
  assign o_err   = r_err;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_i2c_frame_capture.sv
// tb/tb_i2c_frame_capture.sv - self-checking bench for i2c_frame_capture with a frame-level reference model
module tb_i2c_frame_capture;

  localparam int SS = 2;
  localparam int H  = 6;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl   = 1'b1;
  logic        sda   = 1'b1;
  logic [15:0] o_data;
  logic [1:0]  o_ack;
  logic        o_valid;
  logic        o_nack;
  logic        o_err;
  logic        o_busy;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid;
  int n_nack;
  int n_err;
  logic [17:0] cap_q[$];
  logic [15:0] model_data;

  i2c_frame_capture #(.SYNC_STAGES(SS)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_scl  (scl),
    .i_sda  (sda),
    .o_data (o_data),
    .o_ack  (o_ack),
    .o_valid(o_valid),
    .o_nack (o_nack),
    .o_err  (o_err),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && (o_valid || o_nack || o_err)) begin
      vectors++;
      if (int'(o_valid) + int'(o_nack) + int'(o_err) != 1) begin
        miscompares++;
        $display("FAIL strobe_exclusive valid=%b nack=%b err=%b required exactly one", o_valid, o_nack, o_err);
      end
      if (o_valid) begin
        n_valid++;
        cap_q.push_back({o_ack, o_data});
        vectors++;
        if (o_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_at_valid got %b required 1", o_busy);
        end
      end
      if (o_nack) n_nack++;
      if (o_err)  n_err++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_nack  = 0;
    n_err   = 0;
    cap_q.delete();
  endtask

  task automatic start_cond();
    sda = 1'b1; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    sda = 1'b0; wait_clk(H);
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic stop_cond();
    sda = 1'b0; wait_clk(H);
    scl = 1'b1; wait_clk(H);
    sda = 1'b1; wait_clk(H);
    wait_clk(10);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    wait_clk(H);
    scl = 1'b1; wait_clk(H);
    scl = 1'b0; wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
    wait_clk(3);
    vectors++;
    if ({o_data, o_ack, o_valid, o_nack, o_err, o_busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_in got %h required 0", {o_data, o_ack, o_valid, o_nack, o_err, o_busy});
    end
    rst_n = 1'b1;
    clear_counts();
    wait_clk(20);
    vectors++;
    if ({o_data, o_ack, o_valid, o_nack, o_err, o_busy} !== 22'd0 || n_valid + n_nack + n_err != 0) begin
      miscompares++;
      $display("FAIL reset_idle got %h strobes %0d required 0", {o_data, o_ack, o_valid, o_nack, o_err, o_busy},
               n_valid + n_nack + n_err);
    end
    model_data = 16'h0000;
  endtask

  task automatic test_basic();
    int lat;
    clear_counts();
    lat = 0;
    sda = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (o_busy) begin lat = i; break; end
    end
    vectors++;
    if (lat != SS + 2) begin
      miscompares++;
      $display("FAIL start_latency got %0d required %0d", lat, SS + 2);
    end
    wait_clk(H);
    scl = 1'b0; wait_clk(H);
    send_byte(8'hA4, 1'b0);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_mid got %b required 1", o_busy);
    end
    send_byte(8'h5C, 1'b0);
    stop_cond();
    vectors++;
    if (n_valid != 1 || o_data !== 16'hA45C || o_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL basic_frame valid=%0d data=%h ack=%b required 1 a45c 00", n_valid, o_data, o_ack);
    end
    vectors++;
    if (n_err != 0 || n_nack != 0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_flags err=%0d nack=%0d busy=%b required 0 0 0", n_err, n_nack, o_busy);
    end
    model_data = 16'hA45C;
  endtask

  task automatic test_addr_nack();
    clear_counts();
    start_cond();
    send_byte(8'h91, 1'b1);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    stop_cond();
    vectors++;
    if (n_nack != 1 || n_valid != 0 || n_err != 0 || o_data !== 16'hA45C) begin
      miscompares++;
      $display("FAIL addr_nack nack=%0d valid=%0d err=%0d data=%h required 1 0 0 a45c", n_nack, n_valid, n_err, o_data);
    end
  endtask

  task automatic test_data_nack();
    clear_counts();
    start_cond();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b0);
    stop_cond();
    vectors++;
    if (n_valid != 1 || o_data !== 16'h3CFF || o_ack !== 2'b01 || n_nack != 0 || n_err != 0) begin
      miscompares++;
      $display("FAIL data_nack valid=%0d data=%h ack=%b nack=%0d err=%0d required 1 3cff 01 0 0",
               n_valid, o_data, o_ack, n_nack, n_err);
    end
  endtask

  task automatic test_repeated_start();
    clear_counts();
    start_cond();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    start_cond();
    vectors++;
    if (n_err != 1 || n_valid != 0) begin
      miscompares++;
      $display("FAIL rstart_err err=%0d valid=%0d required 1 0", n_err, n_valid);
    end
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    stop_cond();
    vectors++;
    if (n_valid != 1 || o_data !== 16'h1020 || n_err != 1) begin
      miscompares++;
      $display("FAIL rstart_frame valid=%0d data=%h err=%0d required 1 1020 1", n_valid, o_data, n_err);
    end
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    start_cond();
    send_byte(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_data, o_ack, o_valid, o_nack, o_err, o_busy} !== 22'd0) begin
        miscompares++;
        $display("FAIL midreset_out got %h required 0", {o_data, o_ack, o_valid, o_nack, o_err, o_busy});
      end
    end
    rst_n = 1'b1;
    start_cond();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    stop_cond();
    vectors++;
    if (n_valid != 1 || o_data !== 16'h0102 || n_err != 0 || n_nack != 0) begin
      miscompares++;
      $display("FAIL midreset_frame valid=%0d data=%h err=%0d nack=%0d required 1 0102 0 0",
               n_valid, o_data, n_err, n_nack);
    end
    model_data = 16'h0102;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    start_cond();
    send_byte(8'hC3, 1'b0);
    send_byte(8'h5A, 1'b1);
    start_cond();
    send_byte(8'h81, 1'b0);
    send_byte(8'h7E, 1'b0);
    stop_cond();
    vectors++;
    if (n_valid != 2 || n_err != 0 || cap_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_count valid=%0d err=%0d required 2 0", n_valid, n_err);
    end else begin
      vectors++;
      if (cap_q[0] !== {2'b01, 16'hC35A} || cap_q[1] !== {2'b00, 16'h817E}) begin
        miscompares++;
        $display("FAIL b2b_data got %h %h required 1c35a 0817e", cap_q[0], cap_q[1]);
      end
    end
    model_data = 16'h817E;
  endtask

  task automatic test_random();
    logic [7:0] b0, b1;
    logic       a0, a1;
    int         extra;
    for (int it = 0; it < 25; it++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      a0 = ($urandom_range(0, 3) == 0);
      a1 = 1'($urandom);
      extra = $urandom_range(0, 2);
      clear_counts();
      start_cond();
      send_byte(b0, a0);
      send_byte(b1, a1);
      for (int k = 0; k < extra; k++) send_byte(8'($urandom), 1'($urandom));
      stop_cond();
      vectors++;
      if (a0) begin
        if (n_nack != 1 || n_valid != 0 || n_err != 0 || o_data !== model_data) begin
          miscompares++;
          $display("FAIL rand_nack it=%0d nack=%0d valid=%0d err=%0d data=%h required 1 0 0 %h",
                   it, n_nack, n_valid, n_err, o_data, model_data);
        end
      end else begin
        model_data = b0 * 256 + b1;
        if (n_valid != 1 || n_nack != 0 || n_err != 0 || o_data !== model_data || o_ack !== {1'b0, a1}) begin
          miscompares++;
          $display("FAIL rand_frame it=%0d valid=%0d nack=%0d err=%0d data=%h ack=%b required 1 0 0 %h 0%b",
                   it, n_valid, n_nack, n_err, o_data, o_ack, model_data, a1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_nack();
    test_data_nack();
    test_repeated_start();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
